pll_clk_ctrl: RTL and testbench

Clock-control register and clock-enable generator for the XLR8 core, sitting beside the PLL and internal-oscillator primitives. It provides the PRR power-reduction register and derives the 16 MHz, 1 MHz and 128 kHz timer enables from the CPU clock. It also divides the internal-oscillator tick stream and generates a power-on reset qualified by PLL lock. All logic runs on a single clock; the PLL and oscillator primitives stay outside this block.

---
 rtl/pll_clk_ctrl.sv | 159 +++++++++++++++
 tb/tb_pll_clk_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/pll_clk_ctrl.sv
// PRR power-reduction register, timer clock-enable generator, oscillator divider and
// lock-qualified power-on reset. Optional macro: SIM_FAST_WATCHDOG_EN (short 128 kHz period).
module pll_clk_ctrl #(
  parameter int          CLOCK_SELECT    = 0,
  parameter logic [7:0]  PRR_ADDR        = 8'h64,
  parameter int          PRADC_BIT       = 0,
  parameter int          PRUSART0_BIT    = 1,
  parameter int          PRSPI_BIT       = 2,
  parameter int          PRTIM1_BIT      = 3,
  parameter int          PRINTOSC_BIT    = 4,
  parameter int          PRTIM0_BIT      = 5,
  parameter int          PRTIM2_BIT      = 6,
  parameter int          PRTWI_BIT       = 7,
  parameter int          FAST_WDT_PERIOD = 10
) (
  input  logic       Clock,
  input  logic       core_rstn,
  input  logic       pll_locked,
  input  logic [5:0] adr,
  input  logic       iore,
  input  logic       iowe,
  input  logic [7:0] ramadr,
  input  logic       ramre,
  input  logic       ramwe,
  input  logic       dm_sel,
  input  logic [7:0] dbus_in,
  output logic [7:0] dbus_out,
  output logic       io_out_en,
  input  logic       osc_tick,
  output logic       intosc_en,
  output logic       intosc_div1024,
  output logic       en16mhz,
  output logic       en1mhz,
  output logic       en128khz,
  output logic       pwr_on_nrst
);

  localparam int W = CLOCK_SELECT + 4;
  localparam bit DM_BUS = (PRR_ADDR >= 8'h60);
  localparam logic [7:0] PRR_BITS = 8'((1 << PRADC_BIT) | (1 << PRUSART0_BIT) |
    (1 << PRSPI_BIT) | (1 << PRTIM1_BIT) | (1 << PRINTOSC_BIT) | (1 << PRTIM0_BIT) |
    (1 << PRTIM2_BIT) | (1 << PRTWI_BIT));

`ifdef SIM_FAST_WATCHDOG_EN
  localparam logic [6:0] WDT_RELOAD = 7'(FAST_WDT_PERIOD - 1);
`ifndef SYNTHESIS
  initial $display("pll_clk_ctrl: fast watchdog enabled, 128 kHz period %0d", FAST_WDT_PERIOD);
`endif
`else
  localparam logic [6:0] WDT_RELOAD = 7'd124;
  localparam int unused_fast_wdt = FAST_WDT_PERIOD;
`endif

  logic          prr_sel, prr_we, prr_re;
  logic          printosc;
  logic [7:0]    prr_val;
  logic [9:0]    osc_cnt;
  logic [W-1:0]  cnt1m;
  logic [6:0]    cnt128k;
  logic          por_q1, por_q2;
  logic          unused_dbus;

  assign unused_dbus = ^dbus_in;

  // Read/write strobes are single-cycle: a read strobe returns data and io_out_en
  // in the same cycle, a write strobe updates PRR on the following edge.
  always_comb begin
    prr_sel = 1'b0;
    prr_we  = 1'b0;
    prr_re  = 1'b0;
    if (DM_BUS) begin
      prr_sel = dm_sel && (ramadr == PRR_ADDR);
      prr_we  = prr_sel && ramwe;
      prr_re  = prr_sel && ramre;
    end else begin
      prr_sel = (adr == PRR_ADDR[5:0]);
      prr_we  = prr_sel && iowe;
      prr_re  = prr_sel && iore;
    end
  end

  // Only PRINTOSC is stored; every other PRR bit reads as zero.
  always_comb begin
    prr_val = '0;
    prr_val[PRINTOSC_BIT] = printosc;
  end

  assign dbus_out  = prr_sel ? (prr_val & PRR_BITS) : 8'h00;
  assign io_out_en = prr_re;
  assign intosc_en = !printosc;
  assign intosc_div1024 = osc_cnt[9];
  assign pwr_on_nrst = por_q2;

  always_ff @(posedge Clock or negedge core_rstn) begin
    if (!core_rstn) begin
      printosc <= 1'b0;
      osc_cnt  <= '0;
    end else begin
      if (prr_we) printosc <= dbus_in[PRINTOSC_BIT];
      if (osc_tick && intosc_en) osc_cnt <= osc_cnt + 10'd1;
    end
  end

  always_ff @(posedge Clock or negedge core_rstn) begin
    if (!core_rstn) begin
      cnt1m  <= '0;
      en1mhz <= 1'b0;
    end else if (cnt1m == '0) begin
      cnt1m  <= '1;
      en1mhz <= 1'b1;
    end else begin
      cnt1m  <= cnt1m - 1'b1;
      en1mhz <= 1'b0;
    end
  end

  generate
    if (W < 5) begin : g_en16_const
      assign en16mhz = 1'b1;
    end else begin : g_en16_reg
      logic en16_q;
      always_ff @(posedge Clock or negedge core_rstn) begin
        if (!core_rstn) en16_q <= 1'b0;
        else            en16_q <= ~|cnt1m[W-5:0];
      end
      assign en16mhz = en16_q;
    end
  endgenerate

  always_ff @(posedge Clock or negedge core_rstn) begin
    if (!core_rstn) begin
      cnt128k  <= '0;
      en128khz <= 1'b0;
    end else if (!en16mhz) begin
      en128khz <= 1'b0;
    end else if (cnt128k == '0) begin
      cnt128k  <= WDT_RELOAD;
      en128khz <= 1'b1;
    end else begin
      cnt128k  <= cnt128k - 7'd1;
      en128khz <= 1'b0;
    end
  end

  // Losing lock drops the power-on reset on the very next edge.
  always_ff @(posedge Clock or negedge core_rstn) begin
    if (!core_rstn) begin
      por_q1 <= 1'b0;
      por_q2 <= 1'b0;
    end else if (!pll_locked) begin
      por_q1 <= 1'b0;
      por_q2 <= 1'b0;
    end else begin
      por_q1 <= 1'b1;
      por_q2 <= por_q1;
    end
  end

endmodule

// File: tb/tb_pll_clk_ctrl.sv
// Directed bench for pll_clk_ctrl: an I/O-bus 16 MHz instance and a data-bus 64 MHz instance.
module tb_pll_clk_ctrl;

  logic       clk = 1'b0;
  logic       core_rstn;
  logic       pll_locked;
  logic [5:0] adr;
  logic       iore, iowe;
  logic [7:0] ramadr;
  logic       ramre, ramwe, dm_sel;
  logic [7:0] dbus_in;
  logic       osc_tick;

  logic [7:0] d0_dbus_out, d2_dbus_out;
  logic d0_io_out_en, d0_intosc_en, d0_div, d0_en16, d0_en1, d0_en128, d0_pwr;
  logic d2_io_out_en, d2_intosc_en, d2_div, d2_en16, d2_en1, d2_en128, d2_pwr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pll_clk_ctrl #(.CLOCK_SELECT(0), .PRR_ADDR(8'h04)) dut0 (
    .Clock(clk), .core_rstn(core_rstn), .pll_locked(pll_locked),
    .adr(adr), .iore(iore), .iowe(iowe), .ramadr(ramadr), .ramre(ramre),
    .ramwe(ramwe), .dm_sel(dm_sel), .dbus_in(dbus_in), .dbus_out(d0_dbus_out),
    .io_out_en(d0_io_out_en), .osc_tick(osc_tick), .intosc_en(d0_intosc_en),
    .intosc_div1024(d0_div), .en16mhz(d0_en16), .en1mhz(d0_en1),
    .en128khz(d0_en128), .pwr_on_nrst(d0_pwr)
  );

  pll_clk_ctrl #(.CLOCK_SELECT(2), .PRR_ADDR(8'h64)) dut2 (
    .Clock(clk), .core_rstn(core_rstn), .pll_locked(pll_locked),
    .adr(adr), .iore(iore), .iowe(iowe), .ramadr(ramadr), .ramre(ramre),
    .ramwe(ramwe), .dm_sel(dm_sel), .dbus_in(dbus_in), .dbus_out(d2_dbus_out),
    .io_out_en(d2_io_out_en), .osc_tick(osc_tick), .intosc_en(d2_intosc_en),
    .intosc_div1024(d2_div), .en16mhz(d2_en16), .en1mhz(d2_en1),
    .en128khz(d2_en128), .pwr_on_nrst(d2_pwr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    core_rstn = 1'b0; pll_locked = 1'b0; adr = '0; iore = 0; iowe = 0;
    ramadr = '0; ramre = 0; ramwe = 0; dm_sel = 0; dbus_in = '0; osc_tick = 0;

    // Reset state
    #12;
    chk("rst_d0_en1", d0_en1, 0);        chk("rst_d2_en1", d2_en1, 0);
    chk("rst_d0_en16", d0_en16, 1);      chk("rst_d2_en16", d2_en16, 0);
    chk("rst_d0_en128", d0_en128, 0);    chk("rst_d2_en128", d2_en128, 0);
    chk("rst_d0_pwr", d0_pwr, 0);        chk("rst_d0_intosc_en", d0_intosc_en, 1);
    chk("rst_d0_div", d0_div, 0);        chk("rst_d0_ioen", d0_io_out_en, 0);

    tick();
    core_rstn = 1'b1;

    // Enable timing: closed-form pulse positions by edge number after release
    for (int e = 1; e <= 520; e++) begin
      tick();
      chk($sformatf("d0_en1_e%0d", e), d0_en1, (e % 16) == 1);
      chk($sformatf("d2_en1_e%0d", e), d2_en1, (e % 64) == 1);
      chk($sformatf("d0_en16_e%0d", e), d0_en16, 1);
      chk($sformatf("d2_en16_e%0d", e), d2_en16, (e % 4) == 1);
      chk($sformatf("d0_en128_e%0d", e), d0_en128, (e % 125) == 1);
      chk($sformatf("d2_en128_e%0d", e), d2_en128, (e >= 2) && ((e - 2) % 500 == 0));
    end
    chk("por_unlocked", d0_pwr, 0);

    // Power-on reset
    pll_locked = 1'b1;
    tick(); chk("por_edge1", d0_pwr, 0);
    tick(); chk("por_edge2", d0_pwr, 1); chk("por_edge2_d2", d2_pwr, 1);
    pll_locked = 1'b0;
    tick(); chk("por_lost", d0_pwr, 0);
    pll_locked = 1'b1;
    tick(); tick(); chk("por_relock", d0_pwr, 1);

    // PRR write over I/O bus on dut0
    adr = 6'h04; dbus_in = 8'hFF; iowe = 1'b1;
    #1 chk("d2_ignores_io", d2_dbus_out, 8'h00);
    chk("d0_pre_write_en", d0_intosc_en, 1);
    tick(); iowe = 1'b0;
    chk("d0_intosc_off", d0_intosc_en, 0);
    iore = 1'b1; #1;
    chk("d0_rd_data", d0_dbus_out, 8'h10); chk("d0_rd_en", d0_io_out_en, 1);
    adr = 6'h05; #1;
    chk("d0_other_adr", d0_dbus_out, 8'h00); chk("d0_other_en", d0_io_out_en, 0);
    adr = 6'h24; #1;
    chk("d2_iore_24_en", d2_io_out_en, 0); chk("d2_iore_24_data", d2_dbus_out, 8'h00);
    iore = 1'b0; adr = 6'h00;

    // PRR over data-memory bus on dut2
    dm_sel = 1'b1; ramadr = 8'h64; dbus_in = 8'hFF; ramwe = 1'b1;
    tick(); ramwe = 1'b0; ramre = 1'b1; #1;
    chk("d2_dm_rd_en", d2_io_out_en, 1); chk("d2_dm_rd_data", d2_dbus_out, 8'h10);
    chk("d2_intosc_off", d2_intosc_en, 0);
    ramadr = 8'h65; #1;
    chk("d2_dm_other", d2_dbus_out, 8'h00); chk("d2_dm_other_en", d2_io_out_en, 0);
    ramadr = 8'h64; ramre = 1'b0;

    // Clear PRINTOSC on dut0 only
    adr = 6'h04; dbus_in = 8'h00; iowe = 1'b1;
    tick(); iowe = 1'b0;
    chk("d0_intosc_on", d0_intosc_en, 1); chk("d0_rd_zero", d0_dbus_out, 8'h00);
    chk("d2_still_off", d2_intosc_en, 0);
    adr = 6'h00;

    // Oscillator divider
    osc_tick = 1'b1;
    for (int i = 0; i < 511; i++) tick();
    chk("div_511", d0_div, 0);
    tick(); chk("div_512", d0_div, 1); chk("d2_div_held", d2_div, 0);
    for (int i = 0; i < 511; i++) tick();
    chk("div_1023", d0_div, 1);
    tick(); chk("div_1024", d0_div, 0);
    for (int i = 0; i < 600; i++) tick();
    chk("div_1624", d0_div, 1); chk("d2_div_held2", d2_div, 0);

    // Asynchronous reset mid-operation
    chk("pre_rst_pwr", d0_pwr, 1); chk("pre_rst_d2_rd", d2_dbus_out, 8'h10);
    core_rstn = 1'b0; #1;
    chk("mid_rst_div", d0_div, 0);         chk("mid_rst_pwr", d0_pwr, 0);
    chk("mid_rst_d2_pwr", d2_pwr, 0);      chk("mid_rst_d2_intosc", d2_intosc_en, 1);
    chk("mid_rst_d2_rd", d2_dbus_out, 8'h00);
    chk("mid_rst_d0_en1", d0_en1, 0);      chk("mid_rst_d2_en16", d2_en16, 0);
    chk("mid_rst_d0_en128", d0_en128, 0);  chk("mid_rst_d0_en16", d0_en16, 1);
    osc_tick = 1'b0; dm_sel = 1'b0;
    #20;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
